// File: rtl/fpshift_pkg.sv
// Shared encodings and default sizes for the FP-adder shifter arbiter.
package fpshift_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_SHW   = 6;

  localparam logic SHIFT_RIGHT = 1'b0;
  localparam logic SHIFT_LEFT  = 1'b1;

  localparam logic SRC_ALIGN = 1'b0;
  localparam logic SRC_NORM  = 1'b1;

endpackage

// File: rtl/fpshift_core.sv
// Combinational bidirectional log shifter; right shifts also report a sticky bit
// covering every bit dropped off the low end.
module fpshift_core
  import fpshift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW
) (
  input  logic             dir,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             sticky
);

  logic [WIDTH-1:0] mask;

  always_comb begin
    result = data;
    sticky = 1'b0;
    mask   = '0;
    // Stages run largest first; each right stage ORs its own dropped bits into sticky.
    for (int s = SHW - 1; s >= 0; s--) begin
      if (shamt[s]) begin
        if (dir == SHIFT_LEFT) begin
          result = result << (1 << s);
        end else begin
          mask   = (WIDTH'(1) << (1 << s)) - WIDTH'(1);
          sticky = sticky | (|(result & mask));
          result = result >> (1 << s);
        end
      end
    end
  end

endmodule

// File: rtl/fpshift_arbiter.sv
// Round-robin arbiter sharing one shifter between alignment and normalization,
// with a single registered valid/ready result stage and a saturating conflict counter.
module fpshift_arbiter
  import fpshift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_dir,
  input  logic [2*WIDTH-1:0] req_data,
  input  logic [2*SHW-1:0]   req_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky,
  output logic               out_src,
  output logic [CNT_W-1:0]   conflict_cnt
);

  logic             accept, both, hs, sel;
  logic [1:0]       grant;
  logic             sh_dir, sh_sticky;
  logic [WIDTH-1:0] sh_data, sh_result;
  logic [SHW-1:0]   sh_amt;

  logic             out_valid_q, out_sticky_q, out_src_q, last_gnt_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    both   = &req_valid;
    accept = ~flush & (~out_valid_q | out_ready);
    grant  = req_valid;
    if (both) grant = (last_gnt_q == SRC_NORM) ? 2'b01 : 2'b10;
    req_ready = accept ? grant : 2'b00;
    hs        = |req_ready;
    sel       = grant[1];
    sh_dir    = req_dir[sel];
    sh_data   = sel ? req_data[WIDTH +: WIDTH] : req_data[0 +: WIDTH];
    sh_amt    = sel ? req_shamt[SHW +: SHW] : req_shamt[0 +: SHW];
  end

  fpshift_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .dir    (sh_dir),
    .data   (sh_data),
    .shamt  (sh_amt),
    .result (sh_result),
    .sticky (sh_sticky)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sticky_q <= 1'b0;
      out_src_q    <= SRC_ALIGN;
      last_gnt_q   <= SRC_NORM;
      cnt_q        <= '0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (hs) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= sh_result;
        out_sticky_q <= sh_sticky;
        out_src_q    <= sel;
        last_gnt_q   <= sel;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && both && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sticky   = out_sticky_q;
  assign out_src      = out_src_q;
  assign conflict_cnt = cnt_q;

endmodule
